// File: rtl/lc3_core.sv
// LC-3 subset core: multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer on one req/ready memory port.
// Request outputs are registered; TRAP or an unsupported opcode parks the core in HALT until reset.
module lc3_core #(
   parameter logic [15:0] RESET_PC = 16'h3000,
   parameter int          ADDR_W   = 16
) (
   input  logic              clk,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_ready,
   output logic [15:0]       pc_out,
   output logic [2:0]        nzp,
   output logic              halted,
   output logic              illegal,
   input  logic [2:0]        dbg_sel,
   output logic [15:0]       dbg_reg
);
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT} state_t;

   localparam logic [3:0] OP_BR  = 4'b0000, OP_ADD = 4'b0001, OP_LD  = 4'b0010, OP_ST  = 4'b0011;
   localparam logic [3:0] OP_AND = 4'b0101, OP_LDR = 4'b0110, OP_STR = 4'b0111, OP_NOT = 4'b1001;
   localparam logic [3:0] OP_JMP = 4'b1100, OP_LEA = 4'b1110, OP_TRAP = 4'b1111;

   state_t      r_state;
   logic [15:0] r_pc, r_ir, r_mar, r_mdr, r_a, r_b, r_s, r_mem_wdata;
   logic [15:0] r_regs [0:7];
   logic [2:0]  r_nzp;
   logic        r_mem_req, r_mem_we, r_halted, r_illegal;

   logic [3:0]  w_op;
   logic [2:0]  w_dr;
   logic [15:0] w_off9, w_off6, w_imm5, w_alu_b, w_pc_off, w_mar;
   logic [15:0] w_result, w_next_pc;
   logic        w_wr_en, w_is_mem, w_is_store, w_is_illegal;

   function automatic logic [2:0] f_cc(input logic [15:0] v);
      if (v[15]) return 3'b100;
      if (v == 16'h0000) return 3'b010;
      return 3'b001;
   endfunction

   assign w_op         = r_ir[15:12];
   assign w_dr         = r_ir[11:9];
   assign w_off9       = {{7{r_ir[8]}}, r_ir[8:0]};
   assign w_off6       = {{10{r_ir[5]}}, r_ir[5:0]};
   assign w_imm5       = {{11{r_ir[4]}}, r_ir[4:0]};
   assign w_alu_b      = r_ir[5] ? w_imm5 : r_b;
   assign w_pc_off     = r_pc + w_off9;
   assign w_mar        = (w_op == OP_LD || w_op == OP_ST) ? w_pc_off : (r_a + w_off6);
   assign w_is_store   = (w_op == OP_ST) || (w_op == OP_STR);
   assign w_is_mem     = w_is_store || (w_op == OP_LD) || (w_op == OP_LDR);
   assign w_is_illegal = w_op inside {4'b0100, 4'b1000, 4'b1010, 4'b1011, 4'b1101};

   always_comb begin
      w_result  = 16'h0000;
      w_wr_en   = 1'b0;
      w_next_pc = r_pc;
      case (w_op)
         OP_ADD: begin w_result = r_a + w_alu_b; w_wr_en = 1'b1; end
         OP_AND: begin w_result = r_a & w_alu_b; w_wr_en = 1'b1; end
         OP_NOT: begin w_result = ~r_a;          w_wr_en = 1'b1; end
         OP_LEA: begin w_result = w_pc_off;      w_wr_en = 1'b1; end
         OP_BR:  if (|(r_ir[11:9] & r_nzp)) w_next_pc = w_pc_off;
         OP_JMP: w_next_pc = r_a;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= S_FETCH;
         r_pc        <= RESET_PC;
         r_ir        <= 16'h0000;
         r_mar       <= 16'h0000;
         r_mdr       <= 16'h0000;
         r_a         <= 16'h0000;
         r_b         <= 16'h0000;
         r_s         <= 16'h0000;
         r_nzp       <= 3'b010;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_wdata <= 16'h0000;
         r_halted    <= 1'b0;
         r_illegal   <= 1'b0;
         for (int i = 0; i < 8; i++) r_regs[i] <= 16'h0000;
      end else begin
         case (r_state)
            // A FETCH entered with no request outstanding (after reset or a store) raises it first.
            S_FETCH: begin
               if (!r_mem_req) begin
                  r_mem_req <= 1'b1;
                  r_mem_we  <= 1'b0;
               end else if (mem_ready) begin
                  r_ir      <= mem_rdata;
                  r_pc      <= r_pc + 16'd1;
                  r_mem_req <= 1'b0;
                  r_state   <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_a <= r_regs[r_ir[8:6]];
               r_b <= r_regs[r_ir[2:0]];
               r_s <= r_regs[r_ir[11:9]];
               if (w_op == OP_TRAP) begin
                  r_halted <= 1'b1;
                  r_state  <= S_HALT;
               end else if (w_is_illegal) begin
                  r_halted  <= 1'b1;
                  r_illegal <= 1'b1;
                  r_state   <= S_HALT;
               end else begin
                  r_state <= S_EXECUTE;
               end
            end
            S_EXECUTE: begin
               if (w_wr_en) begin
                  r_regs[w_dr] <= w_result;
                  r_nzp        <= f_cc(w_result);
               end
               r_mem_req <= 1'b1;
               if (w_is_mem) begin
                  r_mar    <= w_mar;
                  r_mem_we <= w_is_store;
                  if (w_is_store) r_mem_wdata <= r_s;
                  r_state  <= S_MEM;
               end else begin
                  r_pc     <= w_next_pc;
                  r_mem_we <= 1'b0;
                  r_state  <= S_FETCH;
               end
            end
            S_MEM: begin
               if (mem_ready) begin
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
                  if (w_is_store) begin
                     r_state <= S_FETCH;
                  end else begin
                     r_mdr   <= mem_rdata;
                     r_state <= S_WB;
                  end
               end
            end
            S_WB: begin
               r_regs[w_dr] <= r_mdr;
               r_nzp        <= f_cc(r_mdr);
               r_mem_req    <= 1'b1;
               r_mem_we     <= 1'b0;
               r_state      <= S_FETCH;
            end
            default: r_state <= S_HALT;
         endcase
      end
   end

   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = (r_state == S_MEM) ? r_mar[ADDR_W-1:0] : r_pc[ADDR_W-1:0];
   assign mem_wdata = r_mem_wdata;
   assign pc_out    = r_pc;
   assign nzp       = r_nzp;
   assign halted    = r_halted;
   assign illegal   = r_illegal;
   assign dbg_reg   = r_regs[dbg_sel];

endmodule
